apb_axi_ab_if: RTL and testbench

APB_AXI_AB_IF -- requirements
Module: apb_axi_ab_if

---
 rtl/apb_axi_mon_pkg.sv | 30 +++
 rtl/axi_hs_stable_chk.sv | 31 +++
 rtl/apb_axi_ab_if.sv | 156 +++++++++++++++
 tb/tb_apb_axi_ab_if.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/apb_axi_mon_pkg.sv
// Shared encodings for the APB/AXI protocol monitor: burst types, error-bit
// indices and the 4 KB boundary width.
package apb_axi_mon_pkg;

   typedef enum logic [1:0] {
      BURST_FIXED = 2'd0,
      BURST_INCR  = 2'd1,
      BURST_WRAP  = 2'd2,
      BURST_RSVD  = 2'd3
   } burst_e;

   localparam int ERR_W            = 10;
   localparam int ERR_APB_NO_SETUP = 0;
   localparam int ERR_APB_NO_ACC   = 1;
   localparam int ERR_APB_UNSTABLE = 2;
   localparam int ERR_APB_PSEL_DRP = 3;
   localparam int ERR_A_RETRACT    = 4;
   localparam int ERR_A_UNSTABLE   = 5;
   localparam int ERR_A_BURST_RSVD = 6;
   localparam int ERR_A_BURST_GEOM = 7;
   localparam int ERR_B_UNSTABLE   = 8;
   localparam int ERR_B_ORPHAN     = 9;

   localparam int BOUNDARY_4K_W = 12;

   function automatic logic wrap_len_ok(input logic [7:0] len);
      return (len == 8'd1) || (len == 8'd3) || (len == 8'd7) || (len == 8'd15);
   endfunction

endpackage

// File: rtl/axi_hs_stable_chk.sv
// Valid/ready channel checker: flags valid retracted, or payload changed,
// after a stalled cycle (valid=1, ready=0).
module axi_hs_stable_chk #(
   parameter int W = 8
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         valid_i,
   input  logic         ready_i,
   input  logic [W-1:0] payload_i,
   output logic         retract_o,
   output logic         change_o
);

   logic         stall_q;
   logic [W-1:0] payload_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stall_q   <= 1'b0;
         payload_q <= '0;
      end else begin
         stall_q   <= valid_i & ~ready_i;
         payload_q <= payload_i;
      end
   end

   assign retract_o = stall_q & ~valid_i;
   assign change_o  = stall_q & valid_i & (payload_i != payload_q);

endmodule

// File: rtl/apb_axi_ab_if.sv
// Passive APB + AXI A/B-channel protocol monitor: sticky error flags,
// transfer counters and an outstanding-transaction count.
module apb_axi_ab_if
   import apb_axi_mon_pkg::*;
#(
   parameter int ADDR_WIDTH = 32,
   parameter int ID_WIDTH   = 4,
   parameter int APB_AW     = 32,
   parameter int APB_DW     = 32,
   parameter int CNT_WIDTH  = 16
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  psel,
   input  logic                  penable,
   input  logic                  pwrite,
   input  logic                  pready,
   input  logic                  pslverr,
   input  logic [APB_AW-1:0]     paddr,
   input  logic [APB_DW-1:0]     pwdata,
   input  logic [APB_DW-1:0]     prdata,
   input  logic                  avalid,
   input  logic                  aready,
   input  logic [ID_WIDTH-1:0]   aid,
   input  logic [ADDR_WIDTH-1:0] aaddr,
   input  logic [7:0]            alen,
   input  logic [2:0]            asize,
   input  logic [1:0]            aburst,
   input  logic                  bvalid,
   input  logic                  bready,
   input  logic [ID_WIDTH-1:0]   bid,
   input  logic [1:0]            bresp,
   input  logic                  err_clr,
   output logic [ERR_W-1:0]      err_vec,
   output logic                  err_pulse,
   output logic [CNT_WIDTH-1:0]  apb_cnt,
   output logic [CNT_WIDTH-1:0]  a_cnt,
   output logic [CNT_WIDTH-1:0]  b_cnt,
   output logic [CNT_WIDTH-1:0]  outstanding
);

   localparam int AP_W = ID_WIDTH + ADDR_WIDTH + 8 + 3 + 2;
   localparam int BP_W = ID_WIDTH + 2;

   logic                  hist_vld_q;
   logic                  setup_q, apb_stall_q, pwrite_q;
   logic [APB_AW-1:0]     paddr_q;
   logic [APB_DW-1:0]     pwdata_q;
   logic [ERR_W-1:0]      err_vec_q, err_vec_d, err_raw, err_now;
   logic                  err_pulse_q;
   logic [CNT_WIDTH-1:0]  apb_cnt_q, a_cnt_q, b_cnt_q, out_q, out_d;
   logic                  apb_setup, apb_access, apb_done, apb_stall, a_hs, b_hs;
   logic                  a_retract, a_change, b_retract, b_change, cross_4k;
   logic [ADDR_WIDTH-1:0] len_bytes, end_addr;
   logic                  unused_ok;

   assign unused_ok  = ^{prdata, pslverr};

   assign apb_setup  = psel & ~penable;
   assign apb_access = psel & penable;
   assign apb_done   = apb_access & pready;
   assign apb_stall  = apb_access & ~pready;
   assign a_hs       = avalid & aready;
   assign b_hs       = bvalid & bready;

   axi_hs_stable_chk #(.W(AP_W)) u_a_chk (
      .clk       (clk),
      .rst_n     (rst_n),
      .valid_i   (avalid),
      .ready_i   (aready),
      .payload_i ({aid, aaddr, alen, asize, aburst}),
      .retract_o (a_retract),
      .change_o  (a_change)
   );

   axi_hs_stable_chk #(.W(BP_W)) u_b_chk (
      .clk       (clk),
      .rst_n     (rst_n),
      .valid_i   (bvalid),
      .ready_i   (bready),
      .payload_i ({bid, bresp}),
      .retract_o (b_retract),
      .change_o  (b_change)
   );

   // Last byte of an INCR burst; any difference above bit 11 means a 4 KB crossing.
   assign len_bytes = (ADDR_WIDTH'(alen) + ADDR_WIDTH'(1)) << asize;
   assign end_addr  = aaddr + len_bytes - ADDR_WIDTH'(1);
   assign cross_4k  = end_addr[ADDR_WIDTH-1:BOUNDARY_4K_W] != aaddr[ADDR_WIDTH-1:BOUNDARY_4K_W];

   always_comb begin
      err_raw = '0;
      err_raw[ERR_APB_NO_SETUP] = apb_access & ~(setup_q | apb_stall_q);
      err_raw[ERR_APB_NO_ACC]   = setup_q & ~apb_access;
      err_raw[ERR_APB_UNSTABLE] = apb_stall_q & apb_access &
                                  ((paddr != paddr_q) | (pwrite != pwrite_q) | (pwdata != pwdata_q));
      err_raw[ERR_APB_PSEL_DRP] = apb_stall_q & ~psel;
      err_raw[ERR_A_RETRACT]    = a_retract;
      err_raw[ERR_A_UNSTABLE]   = a_change;
      err_raw[ERR_A_BURST_RSVD] = avalid & (aburst == BURST_RSVD);
      err_raw[ERR_A_BURST_GEOM] = avalid & (((aburst == BURST_WRAP) & ~wrap_len_ok(alen)) |
                                            ((aburst == BURST_INCR) & cross_4k));
      err_raw[ERR_B_UNSTABLE]   = b_retract | b_change;
      err_raw[ERR_B_ORPHAN]     = b_hs & ~a_hs & (out_q == '0);
      // The first cycle out of reset has no valid history to judge against.
      err_now   = hist_vld_q ? err_raw : '0;
      err_vec_d = (err_clr ? '0 : err_vec_q) | err_now;
   end

   always_comb begin
      out_d = out_q;
      case ({a_hs, b_hs})
         2'b10:   out_d = out_q + CNT_WIDTH'(1);
         2'b01:   if (out_q != '0) out_d = out_q - CNT_WIDTH'(1);
         default: out_d = out_q;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         hist_vld_q  <= 1'b0;
         setup_q     <= 1'b0;
         apb_stall_q <= 1'b0;
         pwrite_q    <= 1'b0;
         paddr_q     <= '0;
         pwdata_q    <= '0;
         err_vec_q   <= '0;
         err_pulse_q <= 1'b0;
         apb_cnt_q   <= '0;
         a_cnt_q     <= '0;
         b_cnt_q     <= '0;
         out_q       <= '0;
      end else begin
         hist_vld_q  <= 1'b1;
         setup_q     <= apb_setup;
         apb_stall_q <= apb_stall;
         pwrite_q    <= pwrite;
         paddr_q     <= paddr;
         pwdata_q    <= pwdata;
         err_vec_q   <= err_vec_d;
         err_pulse_q <= |err_now;
         apb_cnt_q   <= apb_cnt_q + CNT_WIDTH'(apb_done);
         a_cnt_q     <= a_cnt_q + CNT_WIDTH'(a_hs);
         b_cnt_q     <= b_cnt_q + CNT_WIDTH'(b_hs);
         out_q       <= out_d;
      end
   end

   assign err_vec     = err_vec_q;
   assign err_pulse   = err_pulse_q;
   assign apb_cnt     = apb_cnt_q;
   assign a_cnt       = a_cnt_q;
   assign b_cnt       = b_cnt_q;
   assign outstanding = out_q;

endmodule

// File: tb/tb_apb_axi_ab_if.sv
// Directed bench for apb_axi_ab_if: stimulus pushes expected output values
// into a scoreboard queue, a negedge monitor pops and compares them.
module tb_apb_axi_ab_if;

   localparam int F_ERR = 0, F_PULSE = 1, F_APB = 2, F_A = 3, F_B = 4, F_OUT = 5;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        psel, penable, pwrite, pready, pslverr;
   logic [31:0] paddr, pwdata, prdata;
   logic        avalid, aready;
   logic [3:0]  aid;
   logic [31:0] aaddr;
   logic [7:0]  alen;
   logic [2:0]  asize;
   logic [1:0]  aburst;
   logic        bvalid, bready;
   logic [3:0]  bid;
   logic [1:0]  bresp;
   logic        err_clr;
   logic [9:0]  err_vec;
   logic        err_pulse;
   logic [15:0] apb_cnt, a_cnt, b_cnt, outstanding;

   typedef struct {
      string       name;
      int          fld;
      int unsigned exp;
   } exp_t;

   exp_t sb_q[$];
   int   n_chk  = 0;
   int   n_pass = 0;

   always #5 clk = ~clk;

   apb_axi_ab_if dut (
      .clk(clk), .rst_n(rst_n),
      .psel(psel), .penable(penable), .pwrite(pwrite), .pready(pready), .pslverr(pslverr),
      .paddr(paddr), .pwdata(pwdata), .prdata(prdata),
      .avalid(avalid), .aready(aready), .aid(aid), .aaddr(aaddr),
      .alen(alen), .asize(asize), .aburst(aburst),
      .bvalid(bvalid), .bready(bready), .bid(bid), .bresp(bresp),
      .err_clr(err_clr), .err_vec(err_vec), .err_pulse(err_pulse),
      .apb_cnt(apb_cnt), .a_cnt(a_cnt), .b_cnt(b_cnt), .outstanding(outstanding)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic ex(input string n, input int f, input int unsigned v);
      exp_t e;
      e.name = n;
      e.fld  = f;
      e.exp  = v;
      sb_q.push_back(e);
   endtask

   task automatic idle();
      psel = 0; penable = 0; pwrite = 0; pready = 0; pslverr = 0;
      paddr = 0; pwdata = 0; prdata = 0;
      avalid = 0; aready = 0; aid = 0; aaddr = 0; alen = 0; asize = 0; aburst = 0;
      bvalid = 0; bready = 0; bid = 0; bresp = 0;
   endtask

   task automatic ex_all_zero(input string n);
      ex({n, "_err"}, F_ERR, 0);
      ex({n, "_pulse"}, F_PULSE, 0);
      ex({n, "_apb"}, F_APB, 0);
      ex({n, "_a"}, F_A, 0);
      ex({n, "_b"}, F_B, 0);
      ex({n, "_out"}, F_OUT, 0);
   endtask

   always @(negedge clk) begin
      while (sb_q.size() > 0) begin
         exp_t        e;
         int unsigned act;
         e = sb_q.pop_front();
         case (e.fld)
            F_ERR:   act = 32'(err_vec);
            F_PULSE: act = 32'(err_pulse);
            F_APB:   act = 32'(apb_cnt);
            F_A:     act = 32'(a_cnt);
            F_B:     act = 32'(b_cnt);
            default: act = 32'(outstanding);
         endcase
         n_chk++;
         if (act == e.exp) n_pass++;
         else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", e.name, act, e.exp, $time);
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   initial begin
      rst_n = 0; err_clr = 0; idle();
      tick(); tick();
      ex_all_zero("reset");
      rst_n = 1;
      tick();
      ex("first_cycle_err", F_ERR, 0);

      // APB write
      psel = 1; pwrite = 1; paddr = 32'h10; pwdata = 32'hAA; tick();
      penable = 1; pready = 1; tick();
      ex("apb_wr_cnt", F_APB, 1); ex("apb_wr_err", F_ERR, 0);
      idle(); tick();
      ex("apb_idle_err", F_ERR, 0); ex("apb_idle_pulse", F_PULSE, 0);

      // access without setup
      psel = 1; penable = 1; pready = 1; tick();
      ex("nosetup_err", F_ERR, 10'h001); ex("nosetup_pulse", F_PULSE, 1); ex("nosetup_cnt", F_APB, 2);
      idle(); tick();
      ex("nosetup_pulse_drop", F_PULSE, 0); ex("nosetup_sticky", F_ERR, 10'h001);
      err_clr = 1; tick(); err_clr = 0;
      ex("clr_err", F_ERR, 0);

      // A payload change while stalled
      avalid = 1; aaddr = 32'h100; aburst = 2'b01; asize = 3'd2; alen = 8'd0; aid = 4'd5; tick();
      ex("a_stall_ok", F_ERR, 0);
      aaddr = 32'h200; tick();
      ex("a_change_err", F_ERR, 10'h020); ex("a_change_pulse", F_PULSE, 1);
      aready = 1; tick();
      ex("a_hs_cnt", F_A, 1); ex("a_hs_out", F_OUT, 1); ex("a_hs_pulse", F_PULSE, 0);
      idle(); err_clr = 1; tick(); err_clr = 0;
      ex("a_clr", F_ERR, 0);

      // 4 KB boundary and burst encodings
      avalid = 1; aready = 1; aburst = 2'b01; alen = 8'd3; asize = 3'd2; aaddr = 32'hFF4; tick();
      ex("incr_cross", F_ERR, 10'h080); ex("incr_cross_a", F_A, 2);
      aaddr = 32'hFF0; err_clr = 1; tick(); err_clr = 0;
      ex("incr_fit_edge", F_ERR, 0); ex("incr_fit_a", F_A, 3);
      aaddr = 32'hF00; tick();
      ex("incr_inside", F_ERR, 0); ex("incr_inside_out", F_OUT, 4);
      aburst = 2'b10; alen = 8'd2; tick();
      ex("wrap_len_bad", F_ERR, 10'h080); ex("wrap_a", F_A, 5);
      aburst = 2'b11; alen = 8'd0; err_clr = 1; tick(); err_clr = 0;
      ex("rsvd_beats_clr", F_ERR, 10'h040); ex("rsvd_pulse", F_PULSE, 1); ex("rsvd_out", F_OUT, 6);
      idle(); err_clr = 1; tick(); err_clr = 0;
      ex("burst_clr", F_ERR, 0);
      avalid = 1; aready = 1; aburst = 2'b10; alen = 8'd15; asize = 3'd2; aaddr = 32'hF00; tick();
      ex("wrap_len_ok", F_ERR, 0); ex("wrap_ok_a", F_A, 7); ex("wrap_ok_out", F_OUT, 7);

      // simultaneous A and B, then drain B
      aburst = 2'b01; alen = 8'd0; aaddr = 32'h40; bvalid = 1; bready = 1; bid = 4'd1; tick();
      ex("simul_a", F_A, 8); ex("simul_b", F_B, 1); ex("simul_out", F_OUT, 7);
      avalid = 0; aready = 0;
      for (int i = 1; i <= 7; i++) begin
         tick();
         ex($sformatf("drain_out_%0d", i), F_OUT, 32'(7 - i));
         ex($sformatf("drain_b_%0d", i), F_B, 32'(1 + i));
      end
      ex("drain_err", F_ERR, 0);
      tick();
      ex("orphan_err", F_ERR, 10'h200); ex("orphan_out", F_OUT, 0);
      ex("orphan_b", F_B, 9); ex("orphan_pulse", F_PULSE, 1);
      idle(); err_clr = 1; tick(); err_clr = 0;
      ex("orphan_clr", F_ERR, 0);

      // B stability
      bvalid = 1; bready = 0; bid = 4'd3; bresp = 2'd2; tick();
      ex("b_stall_ok", F_ERR, 0);
      bid = 4'd4; tick();
      ex("b_change", F_ERR, 10'h100);
      bvalid = 0; err_clr = 1; tick(); err_clr = 0;
      ex("b_retract_wins_clr", F_ERR, 10'h100); ex("b_retract_pulse", F_PULSE, 1);
      err_clr = 1; tick(); err_clr = 0;
      ex("b_clr", F_ERR, 0);

      // APB protocol errors
      psel = 1; tick();
      ex("setup_ok", F_ERR, 0);
      psel = 0; tick();
      ex("setup_no_access", F_ERR, 10'h002);
      err_clr = 1; tick(); err_clr = 0;
      ex("apb_clr1", F_ERR, 0);
      psel = 1; paddr = 32'h10; pwrite = 0; tick();
      penable = 1; pready = 0; tick();
      ex("apb_stall_ok", F_ERR, 0);
      paddr = 32'h14; tick();
      ex("apb_unstable", F_ERR, 10'h004);
      psel = 0; penable = 0; tick();
      ex("apb_psel_drop", F_ERR, 10'h00C); ex("apb_stall_cnt", F_APB, 2);
      err_clr = 1; tick(); err_clr = 0;
      ex("apb_clr2", F_ERR, 0);

      // reset in the middle of an A stall
      avalid = 1; aready = 0; aaddr = 32'h300; tick();
      ex("pre_reset_err", F_ERR, 0);
      rst_n = 0; tick();
      ex_all_zero("midreset");
      avalid = 0; bvalid = 1; bready = 1; rst_n = 1; tick();
      ex("post_reset_err", F_ERR, 0); ex("post_reset_pulse", F_PULSE, 0);
      ex("post_reset_b", F_B, 1); ex("post_reset_out", F_OUT, 0);
      idle(); tick();
      ex("post_reset_err2", F_ERR, 0);

      tick(); tick();
      n_chk++;
      if (sb_q.size() == 0) n_pass++;
      else $display("FAIL scoreboard_drain: %0d entries left, expected 0", sb_q.size());
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
